// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial word receiver.
// Bit-order encoding matches the shift-register mode it pairs with.
package serial_rx_pkg;

   typedef enum logic [0:0] {RX_IDLE, RX_SHIFT} rx_state_t;

   localparam logic LSB_FIRST = 1'b0;
   localparam logic MSB_FIRST = 1'b1;

endpackage

// File: rtl/rx_out_slot.sv
// One-entry valid/ready output holding register.
// A word arriving while the slot is full and not draining is dropped and flagged.
module rx_out_slot #(
   parameter int WIDTH = 128
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             word_valid,
   input  logic [WIDTH-1:0] word,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] parallel_out,
   output logic             overrun
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             ovr_q, ovr_d;
   logic             can_load;

   assign can_load = !valid_q || out_ready;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ovr_d   = ovr_q;
      if (word_valid && can_load) begin
         // a completing word keeps the slot valid even on a transfer cycle
         valid_d = 1'b1;
         data_d  = word;
      end else if (word_valid) begin
         ovr_d = 1'b1;
      end else if (valid_q && out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         ovr_q   <= ovr_d;
      end
   end

   assign out_valid    = valid_q;
   assign parallel_out = data_q;
   assign overrun      = ovr_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Assembles a qualified serial bitstream (LSB- or MSB-first) into WIDTH-bit words
// and hands each completed word to a one-entry valid/ready output slot.
module serial_word_receiver
   import serial_rx_pkg::*;
#(
   parameter  int WIDTH = 128,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             msb_first,
   input  logic             frame_start,
   input  logic             sin_valid,
   input  logic             sin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] parallel_out,
   output logic [CNT_W-1:0] bit_count,
   output logic             busy,
   output logic             overrun
);

   rx_state_t        state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             order_q, order_d;
   logic             acc, new_frame, cur_order, word_done;
   logic [WIDTH-1:0] shreg_nxt;

   assign acc = enable && sin_valid;
   // a resync or an idle receiver means the accepted bit opens a fresh frame
   assign new_frame = frame_start || (state_q == RX_IDLE);
   assign cur_order = new_frame ? msb_first : order_q;

   always_comb begin
      if (cur_order == MSB_FIRST) shreg_nxt = {shreg_q[WIDTH-2:0], sin};
      else                        shreg_nxt = {sin, shreg_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      order_d   = order_q;
      word_done = 1'b0;
      if (frame_start) begin
         state_d = RX_IDLE;
         cnt_d   = '0;
      end
      if (acc) begin
         shreg_d = shreg_nxt;
         if (new_frame) begin
            order_d = msb_first;
            cnt_d   = CNT_W'(1);
            state_d = RX_SHIFT;
         end else if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_d     = '0;
            state_d   = RX_IDLE;
            word_done = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RX_IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         order_q <= LSB_FIRST;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         order_q <= order_d;
      end
   end

   rx_out_slot #(.WIDTH(WIDTH)) u_slot (
      .clk          (clk),
      .rst          (rst),
      .word_valid   (word_done),
      .word         (shreg_nxt),
      .out_ready    (out_ready),
      .out_valid    (out_valid),
      .parallel_out (parallel_out),
      .overrun      (overrun)
   );

   assign bit_count = cnt_q;
   assign busy      = (state_q == RX_SHIFT);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench: an 8-bit receiver for most scenarios plus a 128-bit one for the wide word.
module tb_serial_word_receiver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, enable, msb_first, frame_start, sin_valid, sin, out_ready;
   logic       o_valid, busy, ovr;
   logic [7:0] o_data;
   logic [3:0] bcnt;

   logic         v128, sin128;
   logic         o128_valid, busy128, ovr128;
   logic [127:0] o128_data;
   logic [7:0]   bcnt128;

   int total = 0;
   int bad   = 0;

   serial_word_receiver #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .enable(enable), .msb_first(msb_first),
      .frame_start(frame_start), .sin_valid(sin_valid), .sin(sin),
      .out_valid(o_valid), .out_ready(out_ready), .parallel_out(o_data),
      .bit_count(bcnt), .busy(busy), .overrun(ovr)
   );

   serial_word_receiver #(.WIDTH(128)) dut128 (
      .clk(clk), .rst(rst), .enable(enable), .msb_first(1'b0),
      .frame_start(1'b0), .sin_valid(v128), .sin(sin128),
      .out_valid(o128_valid), .out_ready(out_ready), .parallel_out(o128_data),
      .bit_count(bcnt128), .busy(busy128), .overrun(ovr128)
   );

   task automatic bit8(input logic b);
      sin_valid = 1'b1;
      sin       = b;
      @(negedge clk);
      sin_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      #12;
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
      total++; if (o_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", o_data); end
      total++; if (bcnt !== 4'd0) begin bad++; $display("FAIL reset_bcnt got=%0d exp=0", bcnt); end
      total++; if (busy !== 1'b0 || ovr !== 1'b0) begin bad++; $display("FAIL reset_flags busy=%b ovr=%b exp=0/0", busy, ovr); end
      total++; if (o128_data !== 128'h0 || o128_valid !== 1'b0) begin bad++; $display("FAIL reset_wide got=%h/%b exp=0/0", o128_data, o128_valid); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_lsb();
      logic [7:0] seq;
      seq = 8'h4D;
      out_ready = 1'b1;
      msb_first = 1'b0;
      for (int i = 0; i < 8; i++) bit8(seq[i]);
      total++; if (o_valid !== 1'b1 || o_data !== 8'h4D) begin bad++; $display("FAIL lsb_word got=%b/%h exp=1/4d", o_valid, o_data); end
      total++; if (bcnt !== 4'd0 || busy !== 1'b0) begin bad++; $display("FAIL lsb_idle bcnt=%0d busy=%b exp=0/0", bcnt, busy); end
      @(negedge clk);
      total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL lsb_drop got=%b exp=0", o_valid); end
   endtask

   task automatic test_msb();
      logic [7:0] seq;
      seq = 8'h4D;
      msb_first = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bit8(seq[i]);
         if (i == 0) msb_first = 1'b0;
         if (i < 7) begin
            total++;
            if (bcnt !== 4'(i + 1) || busy !== 1'b1) begin
               bad++; $display("FAIL msb_bcnt got=%0d/%b exp=%0d/1", bcnt, busy, i + 1);
            end
         end
      end
      total++; if (o_valid !== 1'b1 || o_data !== 8'hB2) begin bad++; $display("FAIL msb_word got=%b/%h exp=1/b2", o_valid, o_data); end
      total++; if (bcnt !== 4'd0) begin bad++; $display("FAIL msb_bcnt_end got=%0d exp=0", bcnt); end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      logic [7:0] w1, w2;
      w1 = 8'hA5; w2 = 8'h3C;
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) bit8(w1[i]);
      total++; if (o_valid !== 1'b1 || o_data !== 8'hA5 || ovr !== 1'b0) begin bad++; $display("FAIL bp_first got=%b/%h/%b exp=1/a5/0", o_valid, o_data, ovr); end
      for (int i = 0; i < 8; i++) bit8(w2[i]);
      total++; if (o_data !== 8'hA5) begin bad++; $display("FAIL bp_hold got=%h exp=a5", o_data); end
      total++; if (ovr !== 1'b1 || o_valid !== 1'b1) begin bad++; $display("FAIL bp_overrun ovr=%b valid=%b exp=1/1", ovr, o_valid); end
      out_ready = 1'b1;
      @(negedge clk);
      total++; if (o_valid !== 1'b0 || ovr !== 1'b1) begin bad++; $display("FAIL bp_drain valid=%b ovr=%b exp=0/1", o_valid, ovr); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] seq;
      seq = 16'h8001;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bit8(seq[i]);
         if (i == 7) begin
            total++; if (o_valid !== 1'b1 || o_data !== 8'h01) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/01", o_valid, o_data); end
         end
         if (i == 8) begin
            total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL b2b_gap got=%b exp=0", o_valid); end
         end
      end
      total++; if (o_valid !== 1'b1 || o_data !== 8'h80 || ovr !== 1'b0) begin bad++; $display("FAIL b2b_second got=%b/%h/%b exp=1/80/0", o_valid, o_data, ovr); end
      @(negedge clk);
   endtask

   task automatic test_resync();
      logic [4:0] part;
      part = 5'b00101;
      do_reset();
      out_ready = 1'b1;
      msb_first = 1'b0;
      for (int i = 0; i < 5; i++) bit8(part[i]);
      frame_start = 1'b1; sin_valid = 1'b1; sin = 1'b1;
      @(negedge clk);
      frame_start = 1'b0; sin_valid = 1'b0;
      total++; if (bcnt !== 4'd1 || busy !== 1'b1) begin bad++; $display("FAIL resync_bit1 got=%0d/%b exp=1/1", bcnt, busy); end
      for (int i = 0; i < 7; i++) bit8(1'b1);
      total++; if (o_valid !== 1'b1 || o_data !== 8'hFF) begin bad++; $display("FAIL resync_word got=%b/%h exp=1/ff", o_valid, o_data); end
      @(negedge clk);
      for (int i = 0; i < 3; i++) bit8(1'b0);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      total++; if (bcnt !== 4'd0 || busy !== 1'b0 || o_valid !== 1'b0) begin bad++; $display("FAIL resync_nobit got=%0d/%b/%b exp=0/0/0", bcnt, busy, o_valid); end
   endtask

   task automatic test_gating();
      logic [7:0] w;
      w = 8'h5A;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) bit8(w[i]);
      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         sin_valid = 1'b1; sin = 1'b1;
         @(negedge clk);
         total++; if (bcnt !== 4'd3) begin bad++; $display("FAIL gate_hold got=%0d exp=3", bcnt); end
      end
      sin_valid = 1'b0;
      enable = 1'b1;
      out_ready = 1'b0;
      for (int i = 3; i < 8; i++) bit8(w[i]);
      total++; if (o_valid !== 1'b1 || o_data !== 8'h5A) begin bad++; $display("FAIL gate_word got=%b/%h exp=1/5a", o_valid, o_data); end
      bit8(1'b1);
      bit8(1'b0);
      total++; if (bcnt !== 4'd2) begin bad++; $display("FAIL gate_partial got=%0d exp=2", bcnt); end
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      total++; if (o_valid !== 1'b0 || o_data !== 8'h00) begin bad++; $display("FAIL async_rst_out got=%b/%h exp=0/00", o_valid, o_data); end
      total++; if (bcnt !== 4'd0 || busy !== 1'b0 || ovr !== 1'b0) begin bad++; $display("FAIL async_rst_state got=%0d/%b/%b exp=0/0/0", bcnt, busy, ovr); end
      @(negedge clk);
      rst = 1'b1;
      out_ready = 1'b1;
   endtask

   task automatic test_wide();
      logic [127:0] p;
      p = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 128; i++) begin
         v128 = 1'b1; sin128 = p[i];
         @(negedge clk);
         if (i == 63) begin
            total++; if (bcnt128 !== 8'd64 || busy128 !== 1'b1) begin bad++; $display("FAIL wide_mid got=%0d/%b exp=64/1", bcnt128, busy128); end
         end
      end
      v128 = 1'b0;
      total++; if (o128_valid !== 1'b1 || o128_data !== p) begin bad++; $display("FAIL wide_word got=%b/%h exp=1/%h", o128_valid, o128_data, p); end
      total++; if (bcnt128 !== 8'd0 || ovr128 !== 1'b0) begin bad++; $display("FAIL wide_idle got=%0d/%b exp=0/0", bcnt128, ovr128); end
      @(negedge clk);
      total++; if (o128_valid !== 1'b0) begin bad++; $display("FAIL wide_drop got=%b exp=0", o128_valid); end
   endtask

   initial begin
      rst = 1'b0; enable = 1'b1; msb_first = 1'b0; frame_start = 1'b0;
      sin_valid = 1'b0; sin = 1'b0; out_ready = 1'b0; v128 = 1'b0; sin128 = 1'b0;
      test_reset();
      test_lsb();
      test_msb();
      test_backpressure();
      test_back_to_back();
      test_resync();
      test_gating();
      test_wide();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
